alu_vector_sequencer: RTL and testbench

- Synthesizable self-test engine that drives the 32-bit ALU (A, B, F in; Y, Zero, Overflow out) from a vector memory and checks its results in hardware.
- Each vector uses the same 101-bit format as the team's ALU vector files. Bit order, MSB first: ExpOverflow, ExpZero, F[2:0], A[31:0], B[31:0], ExpY[31:0].
- Sits between a vector ROM/RAM and the ALU under test. Reports pass/fail, the error count and the first failing index to the board-level status logic.

---
 rtl/alu_vector_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_vector_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_sequencer.sv
// Self-test sequencer: fetches 101-bit ALU vectors, applies them to the ALU under
// test, checks {Y, Zero, Overflow} and reports pass, error count and first failing index.
module alu_vector_sequencer #(
  parameter int ADDR_W = 4,
  parameter int SETTLE = 1,
  parameter int VEC_W  = 101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vectors,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VEC_W-1:0]  mem_data,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_f,
  input  logic [31:0]       alu_y,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_valid
);

  localparam int CW = ADDR_W + 1;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] MAXN = CW'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     idx_q, cnt_q, err_q;
  logic [SW-1:0]     set_q;
  logic [31:0]       exp_y_q, alu_a_q, alu_b_q;
  logic [2:0]        alu_f_q;
  logic              exp_zero_q, exp_ovf_q;
  logic              mem_rd_q, busy_q, done_q, pass_q, ffv_q;
  logic [ADDR_W-1:0] mem_addr_q, ffi_q;

  logic [CW-1:0] idx_d, nv_clamp, err_inc;
  logic          mismatch;

  // Index is one bit wider than the address so a full-depth run ends without wrapping.
  assign idx_d    = idx_q + 1'b1;
  assign nv_clamp = (num_vectors > MAXN) ? MAXN : num_vectors;
  assign err_inc  = (err_q == {CW{1'b1}}) ? err_q : err_q + 1'b1;
  assign mismatch = {alu_y, alu_zero, alu_ovf} != {exp_y_q, exp_zero_q, exp_ovf_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      set_q      <= '0;
      exp_y_q    <= '0;
      exp_zero_q <= 1'b0;
      exp_ovf_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_f_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      ffv_q      <= 1'b0;
      ffi_q      <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_q  <= nv_clamp;
            idx_q  <= '0;
            err_q  <= '0;
            ffv_q  <= 1'b0;
            ffi_q  <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            if (nv_clamp == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q    <= S_FETCH;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= '0;
            end
          end else if (state_q == S_DONE) begin
            // busy drops in the same cycle done rises, so status is never ambiguous.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == '0);
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          {exp_ovf_q, exp_zero_q, alu_f_q, alu_a_q, alu_b_q, exp_y_q} <= mem_data;
          set_q   <= SW'(SETTLE);
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (set_q == SW'(1)) state_q <= S_CHECK;
          else                 set_q   <= set_q - 1'b1;
        end
        S_CHECK: begin
          if (mismatch) begin
            err_q <= err_inc;
            if (!ffv_q) begin
              ffv_q <= 1'b1;
              ffi_q <= idx_q[ADDR_W-1:0];
            end
          end
          idx_q <= idx_d;
          if (idx_d == cnt_q) begin
            state_q <= S_DONE;
          end else begin
            state_q    <= S_FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= idx_d[ADDR_W-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd           = mem_rd_q;
  assign mem_addr         = mem_addr_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_f            = alu_f_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: reference ALU, synchronous vector memory, and a
// scoreboard of expected run results popped by a monitor when done rises.
module tb_alu_vector_sequencer;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [4:0]   num_vectors;
  logic         mem_rd;
  logic [3:0]   mem_addr;
  logic [100:0] mem_data;
  logic [31:0]  alu_a, alu_b, alu_y;
  logic [2:0]   alu_f;
  logic         alu_zero, alu_ovf;
  logic         busy, done, pass, first_fail_valid;
  logic [4:0]   err_count;
  logic [3:0]   first_fail_idx;

  alu_vector_sequencer #(.ADDR_W(4), .SETTLE(1), .VEC_W(101)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU
  always_comb begin
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (alu_f)
      3'b000: alu_y = alu_a & alu_b;
      3'b001: alu_y = alu_a | alu_b;
      3'b010: begin
        alu_y   = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      3'b110: begin
        alu_y   = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
      end
      3'b111: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  logic [100:0] mem [16];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  typedef struct {
    int err; bit ffv; int ffi; bit ps; int done_cyc; int nrd; int rd_base;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;
  int rd_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: counts read strobes and scores every rising edge of done.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd) rd_total++;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done_sb_size", 128'(sb.size()), 128'd1);
        end else begin
          e = sb.pop_front();
          chk("err_count", 128'(err_count), 128'(e.err));
          chk("first_fail_valid", 128'(first_fail_valid), 128'(e.ffv));
          chk("first_fail_idx", 128'(first_fail_idx), 128'(e.ffi));
          chk("pass", 128'(pass), 128'(e.ps));
          chk("busy_at_done", 128'(busy), 128'd0);
          chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
          chk("mem_rd_pulses", 128'(rd_total - e.rd_base), 128'(e.nrd));
        end
      end
      done_prev = done;
    end
  end

  task automatic set_vec(input int i, input logic ovf, input logic zero, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
    mem[i] = {ovf, zero, f, a, b, y};
  endtask

  task automatic load_s1(input bit c0, input bit c1, input bit c2);
    set_vec(0, 1'b0, 1'b0, 3'b010, 32'd5, 32'd3, c0 ? 32'd9 : 32'd8);
    set_vec(1, 1'b0, 1'b1, 3'b110, 32'd5, 32'd5, c1 ? 32'd1 : 32'd0);
    set_vec(2, 1'b0, 1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00,
            c2 ? 32'hF000F001 : 32'hF000F000);
  endtask

  // Done is expected N*4+1 cycles after the start edge (SETTLE=1).
  task automatic start_run(input int nv, input int ncl, input bit psh,
                           input int e, input bit fv, input int fi, input bit ps);
    exp_t x;
    @(negedge clk);
    start       = 1'b1;
    num_vectors = nv[4:0];
    if (psh) begin
      x = '{e, fv, fi, ps, cyc + 1 + ncl * 4 + 1, ncl, rd_total};
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done_timeout", 128'(done), 128'd1);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 128'({mem_rd, mem_addr, alu_a, alu_b, alu_f, busy, done, pass,
                 err_count, first_fail_idx, first_fail_valid}), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_vectors = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset = 1'b0;

    // 1: clean run
    load_s1(1'b0, 1'b0, 1'b0);
    start_run(3, 3, 1'b1, 0, 1'b0, 0, 1'b1);
    chk("busy_during_run", 128'(busy), 128'd1);
    wait_done();

    // 2: vector 1 ExpY corrupted
    load_s1(1'b0, 1'b1, 1'b0);
    start_run(3, 3, 1'b1, 1, 1'b1, 1, 1'b0);
    wait_done();

    // 3: overflow flag mismatch
    set_vec(0, 1'b0, 1'b0, 3'b010, 32'h7FFFFFFF, 32'd1, 32'h80000000);
    start_run(1, 1, 1'b1, 1, 1'b1, 0, 1'b0);
    wait_done();

    // 4: empty run
    start_run(0, 0, 1'b1, 0, 1'b0, 0, 1'b1);
    chk("busy_empty_run", 128'(busy), 128'd0);
    wait_done();

    // 5: reset during SETTLE of vector 1, then a clean rerun
    load_s1(1'b0, 1'b0, 1'b0);
    start_run(3, 3, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_mid_run");
    reset = 1'b0;
    start_run(3, 3, 1'b1, 0, 1'b0, 0, 1'b1);
    wait_done();

    // 6: start while busy is ignored
    start_run(3, 3, 1'b1, 0, 1'b0, 0, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; num_vectors = 5'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // restart from DONE with two bad vectors, then one bad vector: counts must not accumulate
    load_s1(1'b1, 1'b0, 1'b1);
    start_run(3, 3, 1'b1, 2, 1'b1, 0, 1'b0);
    chk("restart_done_clear", 128'(done), 128'd0);
    wait_done();
    load_s1(1'b0, 1'b1, 1'b0);
    start_run(3, 3, 1'b1, 1, 1'b1, 1, 1'b0);
    chk("restart_err_clear", 128'(err_count), 128'd0);
    chk("restart_ffv_clear", 128'(first_fail_valid), 128'd0);
    wait_done();

    // num_vectors above depth clamps to 16; last entry bad
    for (int i = 0; i < 16; i++)
      set_vec(i, 1'b0, 1'b0, 3'b010, 32'(i), 32'd1, (i == 15) ? 32'd0 : 32'(i + 1));
    start_run(20, 16, 1'b1, 1, 1'b1, 15, 1'b0);
    wait_done();

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
